// File: rtl/hit_response_fsm.sv
// hit_response_fsm: turns a landed opponent attack into damage,
// knockback, hitstun and post-hit invulnerability for this player.
module hit_response_fsm #(
    parameter int DMG_MAX       = 999,
    parameter int INVULN_FRAMES = 30,
    parameter int HITSTUN_BASE  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              opp_attack_active,
    input  logic [1:0]        opp_atk_state,
    input  logic              opp_facing_right,
    input  logic              hit_overlap,
    input  logic              respawn,
    output logic [9:0]        damage,
    output logic signed [4:0] kb_vx,
    output logic signed [4:0] kb_vy,
    output logic              hitstun,
    output logic              invuln,
    output logic              hit_pulse
);

    typedef enum logic [1:0] {
        READY,
        HITSTUN,
        INVULN
    } state_t;

    localparam logic [10:0] DMG_CAP = 11'(DMG_MAX);
    localparam logic [8:0]  INV_T   = 9'(INVULN_FRAMES);
    localparam logic [8:0]  STUN_B  = 9'(HITSTUN_BASE);

    state_t             state_q, state_d;
    logic [8:0]         timer_q, timer_d;
    logic               cons_q, cons_d;
    logic [9:0]         dmg_q, dmg_d;
    logic signed [4:0]  vx_q, vx_d;
    logic signed [4:0]  vy_q, vy_d;
    logic               pulse_q, pulse_d;

    logic               is_up;
    logic               is_down;
    logic               is_side;
    logic [3:0]         add_amt;
    logic [3:0]         kb_base;
    logic [10:0]        dmg_sum;
    logic [9:0]         dmg_new;
    logic [6:0]         kb_sum;
    logic [3:0]         kb;
    logic [3:0]         mag_vx;
    logic [3:0]         mag_vy;
    logic               vy_neg;
    logic signed [4:0]  vx_mag_s;
    logic signed [4:0]  vy_mag_s;
    logic signed [4:0]  vx_hit;
    logic signed [4:0]  vy_hit;
    logic               hit_cond;

    assign is_up   = (opp_atk_state == 2'd1);
    assign is_down = (opp_atk_state == 2'd2);
    assign is_side = (opp_atk_state == 2'd3);

    // Per-attack damage and knockback base table.
    always_comb begin
        add_amt = 4'd3;
        kb_base = 4'd2;
        unique case (1'b1)
            is_up: begin
                add_amt = 4'd5;
                kb_base = 4'd3;
            end
            is_down: begin
                add_amt = 4'd6;
                kb_base = 4'd3;
            end
            is_side: begin
                add_amt = 4'd4;
                kb_base = 4'd4;
            end
            default: begin
                add_amt = 4'd3;
                kb_base = 4'd2;
            end
        endcase
    end

    assign dmg_sum = {1'b0, dmg_q} + {7'd0, add_amt};
    assign dmg_new = (dmg_sum > DMG_CAP) ? DMG_CAP[9:0]
                                         : dmg_sum[9:0];
    assign kb_sum  = {3'd0, kb_base} + {1'b0, dmg_new[9:4]};
    assign kb      = (kb_sum > 7'd15) ? 4'd15 : kb_sum[3:0];

    // Knockback direction and magnitude split per attack type.
    always_comb begin
        mag_vx = kb;
        mag_vy = 4'd1;
        vy_neg = 1'b1;
        unique case (1'b1)
            is_up: begin
                mag_vx = 4'd0;
                mag_vy = kb;
                vy_neg = 1'b1;
            end
            is_down: begin
                mag_vx = {1'b0, kb[3:1]};
                mag_vy = kb;
                vy_neg = 1'b0;
            end
            is_side: begin
                mag_vx = kb;
                mag_vy = {1'b0, kb[3:1]};
                vy_neg = 1'b1;
            end
            default: begin
                mag_vx = kb;
                mag_vy = 4'd1;
                vy_neg = 1'b1;
            end
        endcase
    end

    assign vx_mag_s = {1'b0, mag_vx};
    assign vy_mag_s = {1'b0, mag_vy};
    assign vx_hit   = opp_facing_right ? vx_mag_s : -vx_mag_s;
    assign vy_hit   = vy_neg ? -vy_mag_s : vy_mag_s;

    assign hit_cond = (state_q == READY) && opp_attack_active
                   && hit_overlap && !cons_q;

    // Next-state and register updates, gated by the frame tick.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cons_d  = cons_q;
        dmg_d   = dmg_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        pulse_d = 1'b0;
        if (frame_tick) begin
            if (!opp_attack_active) begin
                cons_d = 1'b0;
            end
            if (respawn) begin
                state_d = READY;
                timer_d = 9'd0;
                dmg_d   = 10'd0;
                vx_d    = 5'sd0;
                vy_d    = 5'sd0;
                if (hit_cond) begin
                    cons_d = 1'b1;
                end
            end else if (hit_cond) begin
                state_d = HITSTUN;
                timer_d = STUN_B + {5'd0, kb};
                cons_d  = 1'b1;
                dmg_d   = dmg_new;
                vx_d    = vx_hit;
                vy_d    = vy_hit;
                pulse_d = 1'b1;
            end else begin
                unique case (state_q)
                    HITSTUN: begin
                        if (timer_q == 9'd1) begin
                            state_d = INVULN;
                            timer_d = INV_T;
                            vx_d    = 5'sd0;
                            vy_d    = 5'sd0;
                        end else begin
                            timer_d = timer_q - 9'd1;
                            if (vx_q > 5'sd0) begin
                                vx_d = vx_q - 5'sd1;
                            end else if (vx_q < 5'sd0) begin
                                vx_d = vx_q + 5'sd1;
                            end
                        end
                    end
                    INVULN: begin
                        if (timer_q == 9'd1) begin
                            state_d = READY;
                            timer_d = 9'd0;
                        end else begin
                            timer_d = timer_q - 9'd1;
                        end
                    end
                    READY: begin
                    end
                    default: begin
                        state_d = READY;
                        timer_d = 9'd0;
                    end
                endcase
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= READY;
            timer_q <= 9'd0;
            cons_q  <= 1'b0;
            dmg_q   <= 10'd0;
            vx_q    <= 5'sd0;
            vy_q    <= 5'sd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cons_q  <= cons_d;
            dmg_q   <= dmg_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            pulse_q <= pulse_d;
        end
    end

    assign damage    = dmg_q;
    assign kb_vx     = vx_q;
    assign kb_vy     = vy_q;
    assign hitstun   = (state_q == HITSTUN);
    assign invuln    = (state_q == INVULN);
    assign hit_pulse = pulse_q;

endmodule

// File: tb/tb_hit_response_fsm.sv
// tb_hit_response_fsm: directed and random stimulus against a
// frame-level behavioural model of the hit response.
module tb_hit_response_fsm;

    localparam int DMG_MAX = 999;
    localparam int INV_F   = 30;
    localparam int STUN_B  = 8;

    logic              clk;
    logic              rst;
    logic              frame_tick;
    logic              opp_attack_active;
    logic [1:0]        opp_atk_state;
    logic              opp_facing_right;
    logic              hit_overlap;
    logic              respawn;
    logic [9:0]        damage;
    logic signed [4:0] kb_vx;
    logic signed [4:0] kb_vy;
    logic              hitstun;
    logic              invuln;
    logic              hit_pulse;

    hit_response_fsm #(
        .DMG_MAX      (DMG_MAX),
        .INVULN_FRAMES(INV_F),
        .HITSTUN_BASE (STUN_B)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_tick       (frame_tick),
        .opp_attack_active(opp_attack_active),
        .opp_atk_state    (opp_atk_state),
        .opp_facing_right (opp_facing_right),
        .hit_overlap      (hit_overlap),
        .respawn          (respawn),
        .damage           (damage),
        .kb_vx            (kb_vx),
        .kb_vy            (kb_vy),
        .hitstun          (hitstun),
        .invuln           (invuln),
        .hit_pulse        (hit_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: frames of hitstun / invulnerability still to run.
    int m_dmg, m_vx, m_vy, m_stun, m_inv;
    bit m_cons, m_pulse, m_ok;

    task automatic chk(input string nm, input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d",
                     nm, act, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        int add, base, nd, kb, s;
        bit hitc;
        if (rst) begin
            m_dmg = 0; m_vx = 0; m_vy = 0;
            m_stun = 0; m_inv = 0;
            m_cons = 0; m_pulse = 0; m_ok = 1;
            return;
        end
        m_pulse = 0;
        if (!frame_tick) return;
        hitc = (m_stun == 0) && (m_inv == 0)
            && opp_attack_active && hit_overlap && !m_cons;
        case (opp_atk_state)
            2'd1: begin add = 5; base = 3; end
            2'd2: begin add = 6; base = 3; end
            2'd3: begin add = 4; base = 4; end
            default: begin add = 3; base = 2; end
        endcase
        if (!opp_attack_active) m_cons = 0;
        if (respawn) begin
            m_dmg = 0; m_vx = 0; m_vy = 0;
            m_stun = 0; m_inv = 0;
            if (hitc) m_cons = 1;
        end else if (hitc) begin
            nd = imin(DMG_MAX, m_dmg + add);
            kb = imin(15, base + nd / 16);
            s  = opp_facing_right ? 1 : -1;
            case (opp_atk_state)
                2'd1: begin m_vx = 0; m_vy = -kb; end
                2'd2: begin m_vx = s * (kb / 2); m_vy = kb; end
                2'd3: begin m_vx = s * kb; m_vy = -(kb / 2); end
                default: begin m_vx = s * kb; m_vy = -1; end
            endcase
            m_dmg = nd;
            m_stun = STUN_B + kb;
            m_cons = 1;
            m_pulse = 1;
        end else if (m_stun > 0) begin
            if (m_stun == 1) begin
                m_stun = 0; m_inv = INV_F;
                m_vx = 0; m_vy = 0;
            end else begin
                m_stun--;
                if (m_vx > 0) m_vx--;
                else if (m_vx < 0) m_vx++;
            end
        end else if (m_inv > 0) begin
            m_inv--;
        end
    endtask

    initial begin
        m_ok = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("cmp_damage", int'(damage), m_dmg);
                chk("cmp_kb_vx", int'(kb_vx), m_vx);
                chk("cmp_kb_vy", int'(kb_vy), m_vy);
                chk("cmp_hitstun", int'(hitstun),
                    int'(m_stun != 0));
                chk("cmp_invuln", int'(invuln),
                    int'(m_inv != 0));
                chk("cmp_hit_pulse", int'(hit_pulse),
                    int'(m_pulse));
            end
        end
    end

    // One frame tick; returns just after the ticked edge.
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic recover();
        int g;
        opp_attack_active = 1'b0;
        hit_overlap = 1'b0;
        g = 0;
        while ((m_stun != 0 || m_inv != 0) && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) chk("recover_timeout", g, 0);
        tick();
    endtask

    task automatic do_respawn();
        opp_attack_active = 1'b0;
        hit_overlap = 1'b0;
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
    endtask

    task automatic land(input logic [1:0] t,
                        input logic fr);
        opp_atk_state = t;
        opp_facing_right = fr;
        opp_attack_active = 1'b1;
        hit_overlap = 1'b1;
        tick();
    endtask

    task automatic grind(input int target);
        int rem, g;
        logic [1:0] t;
        g = 0;
        while (m_dmg < target && g < 400) begin
            rem = target - m_dmg;
            if (rem >= 9) t = 2'd2;
            else if (rem > 6) t = 2'd0;
            else if (rem == 6) t = 2'd2;
            else if (rem == 5) t = 2'd1;
            else if (rem == 4) t = 2'd3;
            else t = 2'd0;
            land(t, 1'b1);
            recover();
            g++;
        end
        if (g >= 400) chk("grind_timeout", g, 0);
    endtask

    int n;
    int vxs[3];

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        opp_attack_active = 1'b0;
        opp_atk_state = 2'd0;
        opp_facing_right = 1'b1;
        hit_overlap = 1'b0;
        respawn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_damage", int'(damage), 0);
        chk("rst_hitstun", int'(hitstun), 0);
        chk("rst_invuln", int'(invuln), 0);
        chk("rst_pulse", int'(hit_pulse), 0);
        rst = 1'b0;

        land(2'd0, 1'b1);
        chk("neu_damage", int'(damage), 3);
        chk("neu_vx", int'(kb_vx), 2);
        chk("neu_vy", int'(kb_vy), -1);
        chk("neu_pulse", int'(hit_pulse), 1);
        @(negedge clk);
        chk("neu_pulse_clr", int'(hit_pulse), 0);
        n = 0;
        while (hitstun && n < 300) begin
            if (n < 3) vxs[n] = int'(kb_vx);
            n++;
            tick();
        end
        chk("neu_stun_len", n, 10);
        chk("neu_vx0", vxs[0], 2);
        chk("neu_vx1", vxs[1], 1);
        chk("neu_vx2", vxs[2], 0);
        n = 0;
        while (invuln && n < 300) begin
            n++;
            tick();
        end
        chk("neu_inv_len", n, 30);
        repeat (60) tick();
        chk("hold_one_hit", int'(damage), 3);
        opp_attack_active = 1'b0;
        tick();
        opp_attack_active = 1'b1;
        tick();
        chk("rehit_damage", int'(damage), 6);

        n = 0;
        while (m_stun != 0 && n < 300) begin
            n++;
            tick();
        end
        chk("inv_entered", int'(invuln), 1);
        opp_attack_active = 1'b0;
        tick();
        opp_attack_active = 1'b1;
        opp_atk_state = 2'd2;
        tick();
        chk("inv_no_dmg", int'(damage), 6);
        chk("inv_no_pulse", int'(hit_pulse), 0);
        recover();

        land(2'd1, 1'b1);
        tick();
        tick();
        chk("mid_stun", int'(hitstun), 1);
        opp_attack_active = 1'b0;
        hit_overlap = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_damage", int'(damage), 0);
        chk("rst2_vx", int'(kb_vx), 0);
        chk("rst2_vy", int'(kb_vy), 0);
        chk("rst2_stun", int'(hitstun), 0);
        chk("rst2_inv", int'(invuln), 0);
        chk("rst2_pulse", int'(hit_pulse), 0);

        land(2'd0, 1'b1);
        recover();
        opp_attack_active = 1'b1;
        hit_overlap = 1'b1;
        opp_atk_state = 2'd0;
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
        chk("rsp_damage", int'(damage), 0);
        chk("rsp_pulse", int'(hit_pulse), 0);
        chk("rsp_stun", int'(hitstun), 0);
        repeat (3) tick();
        chk("rsp_consumed", int'(damage), 0);
        opp_attack_active = 1'b0;
        tick();
        opp_attack_active = 1'b1;
        tick();
        chk("rsp_rehit", int'(damage), 3);
        recover();

        do_respawn();
        land(2'd2, 1'b0);
        chk("down_damage", int'(damage), 6);
        chk("down_vx", int'(kb_vx), -1);
        chk("down_vy", int'(kb_vy), 3);
        recover();

        do_respawn();
        grind(32);
        chk("pre_up_damage", int'(damage), 32);
        land(2'd1, 1'b1);
        chk("up_damage", int'(damage), 37);
        chk("up_vx", int'(kb_vx), 0);
        chk("up_vy", int'(kb_vy), -5);
        recover();

        do_respawn();
        grind(995);
        chk("pre_sat_damage", int'(damage), 995);
        land(2'd3, 1'b0);
        chk("sat_damage", int'(damage), 999);
        chk("sat_vx", int'(kb_vx), -15);
        chk("sat_vy", int'(kb_vy), -7);
        n = 0;
        while (hitstun && n < 300) begin
            n++;
            tick();
        end
        chk("sat_stun_len", n, 23);
        recover();
        land(2'd2, 1'b1);
        chk("sat_hold", int'(damage), 999);
        recover();

        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            frame_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                opp_attack_active = ~opp_attack_active;
            hit_overlap = ($urandom_range(0, 3) != 0);
            opp_atk_state = 2'($urandom_range(0, 3));
            opp_facing_right = 1'($urandom_range(0, 1));
            respawn = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        frame_tick = 1'b0;
        respawn = 1'b0;
        rst = 1'b0;
        opp_attack_active = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_response_fsm.md
# hit_response_fsm

Defender-side counterpart to the per-player attack state machine: consumes the opponent's attack outputs plus a hitbox-overlap flag and turns a landed attack into damage, knockback velocity, hitstun and post-hit invulnerability for this player. It sits between the opponent's attack FSM, the collision checker and this player's movement/physics block. All game-state updates advance on `frame_tick`.

## Interface

Parameters:

- `DMG_MAX`, default 999: damage saturation value. Range 1..1023.
- `INVULN_FRAMES`, default 30: invulnerability length in frames after hitstun. Range 1..255.
- `HITSTUN_BASE`, default 8: frames added to knockback magnitude to form the hitstun length.

Ports (single clock `clk`; reset `rst` is synchronous and active-high):

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-`clk` pulse per video frame.
- `opp_attack_active` in 1: opponent attack in progress.
- `opp_atk_state` in 2: opponent `attack_state`. NEUTRAL=0, ATK_UP=1, ATK_DOWN=2, ATK_SIDE=3.
- `opp_facing_right` in 1: opponent facing direction. 1 means knockback goes to +x.
- `hit_overlap` in 1: opponent hitbox overlaps this player's hurtbox.
- `respawn` in 1: clear damage and recover.
- `damage` out 10: accumulated damage percent.
- `kb_vx` out 5: signed knockback x velocity.
- `kb_vy` out 5: signed knockback y velocity, where +y is downward.
- `hitstun` out 1: player cannot act.
- `invuln` out 1: hits are ignored.
- `hit_pulse` out 1: one-`clk` strobe when a hit lands.

## Operation

- States:
  - READY
  - HITSTUN
  - INVULN
- Evaluation: every transition and register update below happens only on a `clk` edge with `frame_tick`=1. The only exceptions are `rst` and the `hit_pulse` clear.
- Reset (`rst`=1): state READY; `damage`=0, `kb_vx`=0, `kb_vy`=0; `hitstun`=0, `invuln`=0, `hit_pulse`=0; timer=0; `consumed`=0.
- One-hit-per-attack rule:
  - `consumed` is set when a hit lands.
  - `consumed` is cleared on any tick where `opp_attack_active`=0.
- A hit lands when all of the following hold: state READY, `opp_attack_active`=1, `hit_overlap`=1, `consumed`=0.
- Damage added per attack type:
  - NEUTRAL: 3
  - UP: 5
  - DOWN: 6
  - SIDE: 4

  New damage is min(`DMG_MAX`, old damage + add).
- Knockback magnitude: kb = min(15, base + (new damage >> 4)). Base per type:
  - NEUTRAL: 2
  - UP: 3
  - DOWN: 3
  - SIDE: 4
- Velocity, where s = +1 if `opp_facing_right` else -1:
  - NEUTRAL: vx = s·kb, vy = -1
  - SIDE: vx = s·kb, vy = -(kb>>1)
  - UP: vx = 0, vy = -kb
  - DOWN: vx = s·(kb>>1), vy = +kb
- On a hit:
  - Go to HITSTUN.
  - timer = `HITSTUN_BASE` + kb.
  - Set `consumed`.
  - Assert `hit_pulse`.
- In HITSTUN, on each tick:
  - If timer==1: go to INVULN, set timer=`INVULN_FRAMES`, zero `kb_vx` and `kb_vy`.
  - Otherwise: decrement timer and move |`kb_vx`| one step toward 0, never crossing 0. `kb_vy` is held.
- In INVULN, on each tick: if timer==1 go to READY, otherwise decrement. Overlapping attacks are ignored, but `consumed` still tracks them.
- Output decode: `hitstun` = (state==HITSTUN); `invuln` = (state==INVULN).
- Respawn (`respawn`=1 on a tick), from any state:
  - `damage`=0, velocities=0.
  - Go to READY with timer=0.
  - A simultaneous hit is discarded, but `consumed` is set if the hit conditions held.
- Priority: `rst` > `respawn` > hit > timer progression.

## Timing

- Hit latency: condition sampled on tick N. On the next `clk`, `damage`, `kb_vx`, `kb_vy` and `hitstun` are updated and `hit_pulse`=1.
- `hit_pulse` clears on the following `clk` edge regardless of `frame_tick`.
- `hitstun` stays high for exactly `HITSTUN_BASE`+kb ticks, counting the hit tick as the first.
- `invuln` stays high for exactly `INVULN_FRAMES` ticks after that.
- First tick on which a new hit can land: the tick after the INVULN→READY transition.
- Inputs are ignored on non-tick cycles, and outputs are stable between ticks apart from `hit_pulse`.
- Signed outputs are two's complement, range -15..15. The value -16 never appears.

## Test plan

- Damage 0, NEUTRAL, `opp_facing_right`=1, overlap on tick 0:
  - Next cycle: `damage`=3, `kb_vx`=+2, `kb_vy`=-1, `hit_pulse` high for one cycle.
  - `hitstun` high for 10 ticks, `kb_vx` going 2, 1, 0.
  - Then `invuln` high for 30 ticks, then READY.
- `opp_attack_active`=1 and `hit_overlap`=1 held for 100 ticks: exactly one hit lands and `damage`=3. Attack dropped for one tick, then reasserted after INVULN ends: a second hit lands and `damage`=6.
- Preload `damage`=995, SIDE, `opp_facing_right`=0:
  - `damage`=999, kb=15, `kb_vx`=-15, `kb_vy`=-7, `hitstun` lasts 23 ticks.
  - A later hit leaves `damage` at 999.
- UP hit at damage 32, giving new damage 37 and kb=3+2=5: `kb_vx`=0, `kb_vy`=-5. DOWN hit at damage 0 from facing left: `kb_vx`=-1, `kb_vy`=+3.
- Fresh attack with overlap during INVULN: no damage change, no `hit_pulse`.
- `rst` asserted mid-HITSTUN: next cycle all outputs are 0 and state is READY. `respawn` on the same tick as a valid hit: `damage`=0, no `hit_pulse`, state READY; the same attack cannot hit again until `opp_attack_active` drops.
